// File: rtl/hdmi_line_reader_if.sv
// Signal bundle between the HDMI line reader, its line-buffer RAM and the pixel timing logic.
// The timing/RAM side uses the master modport; the line reader uses the slave modport.
interface hdmi_line_reader_if;
    logic        lineStart;
    logic        pixelEnable;
    logic [31:0] ramData;
    logic [8:0]  readAddress;
    logic [23:0] pixelRgb;
    logic        pixelValid;
    logic        ready;
    logic        underrun;

    modport master (
        output lineStart,
        output pixelEnable,
        output ramData,
        input  readAddress,
        input  pixelRgb,
        input  pixelValid,
        input  ready,
        input  underrun
    );

    modport slave (
        input  lineStart,
        input  pixelEnable,
        input  ramData,
        output readAddress,
        output pixelRgb,
        output pixelValid,
        output ready,
        output underrun
    );
endinterface

// File: rtl/hdmi_line_reader.sv
// Prefetches a line of packed RGB565 pixel pairs and streams them as horizontally doubled RGB888.
// Define HDMI_HALFWORD_SWAP_EN to emit the upper halfword of each word before the lower one.
module hdmi_line_reader #(
    parameter int WORDS_PER_LINE = 320
) (
    input  logic              clock,
    input  logic              reset,
    hdmi_line_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, FETCH2, ACTIVE, DONE} state_t;

    localparam logic [8:0] LAST_ADDR     = 9'(WORDS_PER_LINE - 1);
    localparam logic [8:0] PREFETCH_ADDR = (WORDS_PER_LINE > 2) ? 9'd2 : LAST_ADDR;

    state_t      state_q, state_d;
    logic [8:0]  read_addr_q, read_addr_d;
    logic [23:0] pixel_rgb_q, pixel_rgb_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        ready_q, ready_d;
    logic        underrun_q, underrun_d;
    logic [31:0] cur_word_q, cur_word_d;
    logic [31:0] next_word_q, next_word_d;
    logic [8:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic        fetch_pend_q, fetch_pend_d;
    logic [15:0] cur_pixel;
    logic        fetch_ok;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // Phases 0/1 repeat the first halfword, phases 2/3 the second one.
    always_comb begin
        cur_pixel = cur_word_q[15:0];
`ifdef HDMI_HALFWORD_SWAP_EN
        cur_pixel = phase_q[1] ? cur_word_q[15:0] : cur_word_q[31:16];
`else
        cur_pixel = phase_q[1] ? cur_word_q[31:16] : cur_word_q[15:0];
`endif
    end

    // readAddress runs two words ahead of curWord until it reaches the last word of the line.
    assign fetch_ok = ({1'b0, word_cnt_q} + 10'd2) <= {1'b0, LAST_ADDR};

    always_comb begin
        state_d       = state_q;
        read_addr_d   = read_addr_q;
        pixel_rgb_d   = pixel_rgb_q;
        pixel_valid_d = 1'b0;
        ready_d       = ready_q;
        underrun_d    = underrun_q;
        cur_word_d    = cur_word_q;
        next_word_d   = next_word_q;
        word_cnt_d    = word_cnt_q;
        phase_d       = phase_q;
        fetch_pend_d  = 1'b0;

        if (fetch_pend_q) begin
            next_word_d = bus.ramData;
        end

        unique case (state_q)
            FETCH0: begin
                read_addr_d = 9'd1;
                state_d     = FETCH1;
            end
            FETCH1: begin
                cur_word_d  = bus.ramData;
                read_addr_d = PREFETCH_ADDR;
                state_d     = FETCH2;
            end
            FETCH2: begin
                next_word_d = bus.ramData;
                ready_d     = 1'b1;
                state_d     = ACTIVE;
            end
            default: ;
        endcase

        if (bus.pixelEnable) begin
            pixel_valid_d = 1'b1;
            if (state_q == ACTIVE && !bus.lineStart) begin
                pixel_rgb_d = rgb565_to_888(cur_pixel);
                if (phase_q == 2'd3) begin
                    phase_d = 2'd0;
                    if (word_cnt_q == LAST_ADDR) begin
                        state_d = DONE;
                        ready_d = 1'b0;
                    end else begin
                        cur_word_d = next_word_q;
                        word_cnt_d = word_cnt_q + 9'd1;
                        if (fetch_ok) begin
                            fetch_pend_d = 1'b1;
                            if (read_addr_q < LAST_ADDR) begin
                                read_addr_d = read_addr_q + 9'd1;
                            end
                        end
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end else begin
                pixel_rgb_d = 24'd0;
                underrun_d  = 1'b1;
            end
        end

        // A new line always wins, whatever the reader was doing.
        if (bus.lineStart) begin
            state_d      = FETCH0;
            read_addr_d  = 9'd0;
            word_cnt_d   = 9'd0;
            phase_d      = 2'd0;
            ready_d      = 1'b0;
            fetch_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            read_addr_q   <= 9'd0;
            pixel_rgb_q   <= 24'd0;
            pixel_valid_q <= 1'b0;
            ready_q       <= 1'b0;
            underrun_q    <= 1'b0;
            cur_word_q    <= 32'd0;
            next_word_q   <= 32'd0;
            word_cnt_q    <= 9'd0;
            phase_q       <= 2'd0;
            fetch_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_addr_q   <= read_addr_d;
            pixel_rgb_q   <= pixel_rgb_d;
            pixel_valid_q <= pixel_valid_d;
            ready_q       <= ready_d;
            underrun_q    <= underrun_d;
            cur_word_q    <= cur_word_d;
            next_word_q   <= next_word_d;
            word_cnt_q    <= word_cnt_d;
            phase_q       <= phase_d;
            fetch_pend_q  <= fetch_pend_d;
        end
    end

    assign bus.readAddress = read_addr_q;
    assign bus.pixelRgb    = pixel_rgb_q;
    assign bus.pixelValid  = pixel_valid_q;
    assign bus.ready       = ready_q;
    assign bus.underrun    = underrun_q;
endmodule

// File: tb/tb_hdmi_line_reader.sv
// Scoreboard bench for hdmi_line_reader: stimulus queues expected pixels, a monitor checks them.
// Honours HDMI_HALFWORD_SWAP_EN for halfword ordering.
module tb_hdmi_line_reader;
    localparam int WPL = 320;

    logic clock = 1'b0;
    logic reset;

    hdmi_line_reader_if bus();

    hdmi_line_reader #(.WORDS_PER_LINE(WPL)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] rgb;
        int unsigned cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monEntry;
    int unsigned cycleCount = 0;
    int          assertCount = 0;
    int          failCount = 0;
    logic [31:0] mem [0:511];
    int          addrVisits [0:511];
    bit          trackEn = 1'b0;
    bit          havePrev = 1'b0;
    logic [8:0]  prevAddr;
    logic [23:0] firstPix [4];
    int          gaps [12] = '{0, 2, 1, 3, 0, 0, 1, 2, 0, 3, 1, 0};

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Line-buffer RAM model: data shows up one cycle after the address.
    always @(posedge clock) bus.ramData <= mem[bus.readAddress];

    // Monitor: every valid pixel must match the head of the queue, in the cycle it was due.
    always @(negedge clock) begin
        if (bus.pixelValid === 1'b1) begin
            assertCount++;
            if (sbq.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpectedValid: got pixel %06h at cycle %0d, none expected",
                         bus.pixelRgb, cycleCount);
            end else begin
                monEntry = sbq.pop_front();
                if (bus.pixelRgb !== monEntry.rgb || cycleCount != monEntry.cyc) begin
                    failCount++;
                    $display("[TB] FAIL pixelOut: got %06h at cycle %0d, expected %06h at cycle %0d",
                             bus.pixelRgb, cycleCount, monEntry.rgb, monEntry.cyc);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cycleCount) begin
            assertCount++;
            failCount++;
            monEntry = sbq.pop_front();
            $display("[TB] FAIL missingValid: expected %06h at cycle %0d, pixelValid low",
                     monEntry.rgb, monEntry.cyc);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] expectedPixel(input int idx);
        logic [31:0] w;
        logic [15:0] p;
        bit          upper;
        int          r5, g6, b5, r8, g8, b8;
        w = mem[idx / 4];
        upper = ((idx % 4) >= 2);
`ifdef HDMI_HALFWORD_SWAP_EN
        upper = !upper;
`endif
        p  = upper ? w[31:16] : w[15:0];
        r5 = int'(p >> 11) & 31;
        g6 = int'(p >> 5) & 63;
        b5 = int'(p) & 31;
        r8 = (r5 << 3) | (r5 >> 2);
        g8 = (g6 << 2) | (g6 >> 4);
        b8 = (b5 << 3) | (b5 >> 2);
        return {r8[7:0], g8[7:0], b8[7:0]};
    endfunction

    task automatic fillConst(input logic [31:0] value);
        for (int i = 0; i < 512; i++) mem[i] = value;
    endtask

    task automatic fillDistinct();
        int h;
        int l;
        for (int i = 0; i < 512; i++) begin
            h = 'hF00F ^ (i * 5);
            l = i * 37 + 257;
            mem[i] = {h[15:0], l[15:0]};
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs; an enable queues the pixel due in the following cycle.
    task automatic applyStimulus(input logic ls, input logic pe, input logic [23:0] expRgb);
        exp_t e;
        bus.lineStart   = ls;
        bus.pixelEnable = pe;
        if (pe) begin
            e.rgb = expRgb;
            e.cyc = cycleCount + 1;
            sbq.push_back(e);
        end
        @(negedge clock);
        bus.lineStart   = 1'b0;
        bus.pixelEnable = 1'b0;
        if (trackEn) begin
            if (!havePrev || bus.readAddress != prevAddr) addrVisits[bus.readAddress]++;
            havePrev = 1'b1;
            prevAddr = bus.readAddress;
        end
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 24'd0);
            n++;
        end
        checkOutput(name, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        int bad;
`ifdef HDMI_HALFWORD_SWAP_EN
        firstPix = '{24'h0000FF, 24'h0000FF, 24'hFF0000, 24'hFF0000};
`else
        firstPix = '{24'hFF0000, 24'hFF0000, 24'h0000FF, 24'h0000FF};
`endif
        bus.lineStart   = 1'b0;
        bus.pixelEnable = 1'b0;
        fillConst(32'h001F_F800);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("resetAddr", 32'(bus.readAddress), 32'd0);
        checkOutput("resetRgb", 32'(bus.pixelRgb), 32'd0);
        checkOutput("resetValid", 32'(bus.pixelValid), 32'd0);
        checkOutput("resetReady", 32'(bus.ready), 32'd0);
        checkOutput("resetUnderrun", 32'(bus.underrun), 32'd0);
        reset = 1'b0;

        // Prefetch latency and first word of a red/blue line.
        applyStimulus(1'b1, 1'b0, 24'd0);
        checkOutput("fetch0Addr", 32'(bus.readAddress), 32'd0);
        checkOutput("fetch0Ready", 32'(bus.ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 24'd0);
        checkOutput("fetch1Addr", 32'(bus.readAddress), 32'd1);
        applyStimulus(1'b0, 1'b0, 24'd0);
        checkOutput("fetch2Addr", 32'(bus.readAddress), 32'd2);
        checkOutput("fetch2Ready", 32'(bus.ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 24'd0);
        checkOutput("readyLatency", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, firstPix[i]);
        repeat (2) applyStimulus(1'b0, 1'b0, 24'd0);
        checkOutput("firstLineUnderrun", 32'(bus.underrun), 32'd0);

        // Full line, back-to-back enables, with read-address coverage.
        fillDistinct();
        for (int i = 0; i < 512; i++) addrVisits[i] = 0;
        havePrev = 1'b0;
        trackEn  = 1'b1;
        applyStimulus(1'b1, 1'b0, 24'd0);
        waitReady("fullLineReady");
        for (int i = 0; i < 4 * WPL; i++) applyStimulus(1'b0, 1'b1, expectedPixel(i));
        trackEn = 1'b0;
        checkOutput("doneReady", 32'(bus.ready), 32'd0);
        checkOutput("doneUnderrun", 32'(bus.underrun), 32'd0);
        checkOutput("doneAddr", 32'(bus.readAddress), 32'(WPL - 1));
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (i < WPL && addrVisits[i] != 1) bad++;
            if (i >= WPL && addrVisits[i] != 0) bad++;
        end
        checkOutput("addrVisitErrors", 32'(bad), 32'd0);

        // One enable past the end of the line.
        applyStimulus(1'b0, 1'b1, 24'd0);
        checkOutput("overrunUnderrun", 32'(bus.underrun), 32'd1);
        checkOutput("overrunAddr", 32'(bus.readAddress), 32'(WPL - 1));
        applyStimulus(1'b0, 1'b0, 24'd0);

        // Reset beats a simultaneous lineStart and clears the sticky flag.
        reset = 1'b1;
        bus.lineStart = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bus.lineStart = 1'b0;
        checkOutput("reset2Underrun", 32'(bus.underrun), 32'd0);
        checkOutput("reset2Addr", 32'(bus.readAddress), 32'd0);
        checkOutput("reset2Ready", 32'(bus.ready), 32'd0);

        // Enable one cycle after lineStart lands in FETCH0.
        applyStimulus(1'b1, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b1, 24'd0);
        checkOutput("earlyUnderrun", 32'(bus.underrun), 32'd1);
        waitReady("earlyLineReady");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, expectedPixel(i));

        // Abort at pixel 600 with a colliding enable, then restart with gapped enables.
        applyStimulus(1'b1, 1'b0, 24'd0);
        waitReady("abortLineReady");
        for (int i = 0; i < 600; i++) applyStimulus(1'b0, 1'b1, expectedPixel(i));
        applyStimulus(1'b1, 1'b1, 24'd0);
        checkOutput("abortAddr", 32'(bus.readAddress), 32'd0);
        checkOutput("abortReady", 32'(bus.ready), 32'd0);
        waitReady("restartReady");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, expectedPixel(i));
            repeat (gaps[i]) applyStimulus(1'b0, 1'b0, 24'd0);
        end
        checkOutput("stickyUnderrun", 32'(bus.underrun), 32'd1);

        // Reset mid-line: the line is gone until a new lineStart.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) applyStimulus(1'b0, 1'b0, 24'd0);
        checkOutput("noAutoRestart", 32'(bus.ready), 32'd0);
        applyStimulus(1'b0, 1'b1, 24'd0);
        checkOutput("idleUnderrun", 32'(bus.underrun), 32'd1);

        // Solid green line with random enable gaps.
        fillConst(32'h07E0_07E0);
        applyStimulus(1'b1, 1'b0, 24'd0);
        waitReady("greenReady");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 24'h00FF00);
            repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 24'd0);
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 24'd0);
        checkOutput("scoreboardDrained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/hdmi_line_reader.md
HDMI_LINE_READER -- requirements
Module: hdmi_line_reader

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 320, meaning 32-bit line-buffer words per source line (range 2..512).
REQ-002 SHALL have port clock  input  1  single clock for all logic (pixel clock side of the line buffer).
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port lineStart  input  1  one-cycle pulse that starts prefetch of a new line.
REQ-005 SHALL have port pixelEnable  input  1  request for one output pixel in this cycle.
REQ-006 SHALL have port ramData  input  32  line-buffer read data; reflects the readAddress of the previous cycle.
REQ-007 SHALL have port readAddress  output  9  registered line-buffer read address.
REQ-008 SHALL have port pixelRgb  output  24  registered RGB888 pixel {R,G,B}.
REQ-009 SHALL have port pixelValid  output  1  pixelRgb carries a buffered pixel this cycle.
REQ-010 SHALL have port ready  output  1  prefetch complete; line can be streamed.
REQ-011 SHALL have port underrun  output  1  sticky error flag.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH0, FETCH1, FETCH2, ACTIVE, DONE.
REQ-013 lineStart SHALL, in any state, move to FETCH0 next cycle with readAddress=0, word counter=0, phase=0, ready=0 (abort of current line).
REQ-014 FETCH0 -> FETCH1 with readAddress=1; FETCH1: capture ramData into curWord, readAddress=2, -> FETCH2; FETCH2: capture ramData into nextWord, -> ACTIVE, ready=1.
REQ-015 Each word SHALL hold two RGB565 pixels, bits 15:0 first then 31:16; each pixel SHALL be emitted twice (horizontal doubling), giving 4 output pixels per word, phase 0..3.
REQ-016 In ACTIVE, pixelEnable in cycle n SHALL give pixelRgb/pixelValid=1 in cycle n+1; without pixelEnable pixelValid=0 and pixelRgb holds.
REQ-017 RGB565->RGB888 SHALL be R={r[4:0],r[4:2]}, G={g[5:0],g[5:4]}, B={b[4:0],b[4:2]}.
REQ-018 On pixelEnable with phase=3: curWord<=nextWord, phase<=0, word counter increments, readAddress increments; ramData in the following cycle SHALL be captured into nextWord.
REQ-019 readAddress SHALL NOT advance past WORDS_PER_LINE-1; fetches beyond line end are suppressed.
REQ-020 Consuming the final pixel (word WORDS_PER_LINE-1, phase 3) SHALL move to DONE and clear ready.
REQ-021 pixelEnable in IDLE, FETCH0-2 or DONE SHALL give pixelValid=1 with pixelRgb=0 next cycle and set underrun.
REQ-022 lineStart and pixelEnable in the same cycle: lineStart wins; the pixel is treated per REQ-021.
REQ-023 underrun SHALL stay 1 until reset.

Reset
REQ-024 reset SHALL force state IDLE, readAddress=0, pixelRgb=0, pixelValid=0, ready=0, underrun=0, curWord=nextWord=0, counters=0; reset overrides lineStart.
REQ-025 reset mid-line SHALL abandon the line; the next line needs a new lineStart.

Configuration
REQ-026 With macro HDMI_HALFWORD_SWAP_EN defined, each word SHALL emit bits 31:16 first, then 15:0; without it, ordering SHALL follow REQ-015.

Verification
REQ-027 reset, lineStart, ramData per address=32'h001F_F800 -> ready=1 four cycles after the lineStart cycle; 4 enables -> pixelRgb FF0000,FF0000,0000FF,0000FF (swap macro: 0000FF,0000FF,FF0000,FF0000).
REQ-028 WORDS_PER_LINE=320, 1280 back-to-back enables after ready -> readAddress 0..319 exactly once each, pixelValid 1280 cycles, DONE, underrun=0.
REQ-029 pixelEnable one cycle after lineStart -> pixelRgb=0, pixelValid=1, underrun=1 sticky through later lines.
REQ-030 lineStart at pixel 600 of a line -> readAddress=0 next cycle, new line's first pixel correct after ready.
REQ-031 1281st enable after line end -> pixelRgb=0, underrun=1, readAddress stays 319.
REQ-032 ramData=32'h07E0_07E0, enables with random gaps -> every valid pixel 00FF00, output order unaffected by gaps.
